// File: rtl/tt_pad_bank_ctrl.sv
// Pad-bank controller: serial config shadow, break-before-make commit sequencer,
// registered pad-control decode and per-pad input synchroniser/deglitcher.
module tt_pad_bank_ctrl #(
    parameter int N_PADS   = 8,
    parameter int TURN_CYC = 4,
    parameter int FILT_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_shift,
    input  logic              cfg_sdi,
    output logic              cfg_sdo,
    input  logic              cfg_apply,
    output logic              cfg_busy,
    input  logic [N_PADS-1:0] core_out,
    input  logic [N_PADS-1:0] core_oe,
    output logic [N_PADS-1:0] core_in,
    input  logic [N_PADS-1:0] pad_Y,
    output logic [N_PADS-1:0] pad_A,
    output logic [N_PADS-1:0] pad_OE,
    output logic [N_PADS-1:0] pad_IE,
    output logic [N_PADS-1:0] pad_SL,
    output logic [N_PADS-1:0] pad_CS,
    output logic [N_PADS-1:0] pad_PD,
    output logic [N_PADS-1:0] pad_PU
);

    // state    | meaning
    // ST_IDLE  | active config in use, pads driven normally
    // ST_DRAIN | all OE held low for TURN_CYC cycles, old pulls/SL/CS kept
    // ST_APPLY | shadow copied into active, OE still held low

    localparam int          SH_W      = N_PADS * 6;
    localparam logic [5:0]  RST_WORD  = 6'b000100;
    localparam logic [7:0]  TURN_LOAD = 8'(TURN_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_APPLY
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        turn_cnt;
    logic [7:0]        turn_cnt_nxt;
    logic              pending;
    logic              pending_nxt;
    logic [SH_W-1:0]   shadow;
    logic [SH_W-1:0]   active;
    logic [SH_W-1:0]   active_nxt;

    logic [N_PADS-1:0] oe_dec;
    logic [N_PADS-1:0] ie_dec;
    logic [N_PADS-1:0] pd_dec;
    logic [N_PADS-1:0] pu_dec;
    logic [N_PADS-1:0] sl_dec;
    logic [N_PADS-1:0] cs_dec;
    logic [1:0]        mode;

    logic [N_PADS-1:0] sync_q1;
    logic [N_PADS-1:0] sync_q2;
    logic [N_PADS-1:0] filt_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= {N_PADS{RST_WORD}};
        end else if (cfg_shift) begin
            shadow <= {shadow[SH_W-2:0], cfg_sdi};
        end
    end

    assign cfg_sdo  = shadow[SH_W-1];
    assign cfg_busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            turn_cnt <= '0;
            pending  <= 1'b0;
            active   <= {N_PADS{RST_WORD}};
        end else begin
            state    <= state_nxt;
            turn_cnt <= turn_cnt_nxt;
            pending  <= pending_nxt;
            active   <= active_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        turn_cnt_nxt = turn_cnt;
        pending_nxt  = pending;
        active_nxt   = active;
        case (state)
            ST_IDLE: begin
                if (cfg_apply) begin
                    state_nxt    = ST_DRAIN;
                    turn_cnt_nxt = TURN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (cfg_apply) begin
                    pending_nxt = 1'b1;
                end
                if (turn_cnt == 8'd0) begin
                    state_nxt = ST_APPLY;
                end else begin
                    turn_cnt_nxt = turn_cnt - 8'd1;
                end
            end
            ST_APPLY: begin
                active_nxt = shadow;
                // A request arriving in this cycle merges with any pending one.
                if (pending || cfg_apply) begin
                    state_nxt    = ST_DRAIN;
                    turn_cnt_nxt = TURN_LOAD;
                    pending_nxt  = 1'b0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Decode from the config the pads will see next, so OE drops on the edge
    // that enters DRAIN and only returns together with the new config.
    always_comb begin
        oe_dec = '0;
        ie_dec = '0;
        pd_dec = '0;
        pu_dec = '0;
        sl_dec = '0;
        cs_dec = '0;
        mode   = '0;
        for (int i = 0; i < N_PADS; i++) begin
            mode      = active_nxt[6*i +: 2];
            ie_dec[i] = mode[0];
            oe_dec[i] = (mode == 2'b10) || ((mode == 2'b11) && core_oe[i]);
            pd_dec[i] = active_nxt[6*i + 2];
            pu_dec[i] = active_nxt[6*i + 3];
            sl_dec[i] = active_nxt[6*i + 4];
            cs_dec[i] = active_nxt[6*i + 5];
        end
        if (state_nxt != ST_IDLE) begin
            oe_dec = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_A  <= '0;
            pad_OE <= '0;
            pad_IE <= '0;
            pad_SL <= '0;
            pad_CS <= '0;
            pad_PD <= '1;
            pad_PU <= '0;
        end else begin
            pad_A  <= core_out;
            pad_OE <= oe_dec;
            pad_IE <= ie_dec;
            pad_SL <= sl_dec;
            pad_CS <= cs_dec;
            pad_PD <= pd_dec;
            pad_PU <= pu_dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= pad_Y;
            sync_q2 <= sync_q1;
        end
    end

    generate
        if (FILT_CYC == 0) begin : g_nofilt
            assign filt_val = sync_q2;
        end else begin : g_filt
            localparam int             CW      = ($clog2(FILT_CYC) > 0) ? $clog2(FILT_CYC) : 1;
            localparam logic [CW-1:0]  FILT_TC = CW'(FILT_CYC - 1);

            logic [N_PADS-1:0]         filt_q;
            logic [N_PADS-1:0][CW-1:0] filt_cnt;

            // Counter runs only while the synced input disagrees with the output.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    filt_q   <= '0;
                    filt_cnt <= '0;
                end else begin
                    for (int i = 0; i < N_PADS; i++) begin
                        if (sync_q2[i] == filt_q[i]) begin
                            filt_cnt[i] <= '0;
                        end else if (filt_cnt[i] == FILT_TC) begin
                            filt_q[i]   <= sync_q2[i];
                            filt_cnt[i] <= '0;
                        end else begin
                            filt_cnt[i] <= filt_cnt[i] + 1'b1;
                        end
                    end
                end
            end

            assign filt_val = filt_q;
        end
    endgenerate

    assign core_in = filt_val & pad_IE;

endmodule

// File: tb/tb_tt_pad_bank_ctrl.sv
// Self-checking bench for tt_pad_bank_ctrl: vector table with an expected-value
// queue for the pad decode, plus directed commit, filter, reset and chain sequences.
module tb_tt_pad_bank_ctrl;

    localparam int N  = 8;
    localparam int SW = N * 6;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cfg_shift = 1'b0;
    logic         cfg_sdi = 1'b0;
    logic         cfg_sdo;
    logic         cfg_apply = 1'b0;
    logic         cfg_busy;
    logic [N-1:0] core_out = '0;
    logic [N-1:0] core_oe = '0;
    logic [N-1:0] core_in;
    logic [N-1:0] pad_Y = '0;
    logic [N-1:0] pad_A, pad_OE, pad_IE, pad_SL, pad_CS, pad_PD, pad_PU;

    tt_pad_bank_ctrl #(.N_PADS(N), .TURN_CYC(4), .FILT_CYC(3)) dut (
        .clk(clk), .rst(rst),
        .cfg_shift(cfg_shift), .cfg_sdi(cfg_sdi), .cfg_sdo(cfg_sdo),
        .cfg_apply(cfg_apply), .cfg_busy(cfg_busy),
        .core_out(core_out), .core_oe(core_oe), .core_in(core_in),
        .pad_Y(pad_Y), .pad_A(pad_A), .pad_OE(pad_OE), .pad_IE(pad_IE),
        .pad_SL(pad_SL), .pad_CS(pad_CS), .pad_PD(pad_PD), .pad_PU(pad_PU)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] co;
        logic [7:0] coe;
        logic [7:0] ea;
        logic [7:0] eoe;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] oe;
    } exp_t;

    vec_t vecs[6];
    exp_t sb_q[$];

    int busy_run = 0;
    int busy_last = 0;
    int busy_rises = 0;
    int oe_viol = 0;

    always @(negedge clk) begin
        if (cfg_busy === 1'b1) begin
            if (busy_run == 0) busy_rises++;
            busy_run++;
            if (pad_OE !== '0) oe_viol++;
        end else if (busy_run != 0) begin
            busy_last = busy_run;
            busy_run  = 0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] pw(input logic [1:0] mode, input logic [1:0] pull,
                                      input logic sl, input logic cs);
        return {cs, sl, pull, mode};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_cfg(input logic [SW-1:0] v);
        for (int i = SW - 1; i >= 0; i--) begin
            cfg_shift = 1'b1;
            cfg_sdi   = v[i];
            tick();
        end
        cfg_shift = 1'b0;
        cfg_sdi   = 1'b0;
    endtask

    task automatic pulse_apply();
        cfg_apply = 1'b1;
        tick();
        cfg_apply = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (cfg_busy && k < 50) begin
            tick();
            k++;
        end
        check(name, cfg_busy, 1'b0);
        tick();
        tick();
    endtask

    task automatic pulse_pad(input int idx, input int width, output int hi_cnt, output int first_hi);
        hi_cnt   = 0;
        first_hi = -1;
        fork
            begin
                pad_Y[idx] = 1'b1;
                repeat (width) tick();
                pad_Y[idx] = 1'b0;
            end
            begin
                for (int n = 1; n <= 16; n++) begin
                    @(posedge clk);
                    #2;
                    if (core_in[idx]) begin
                        hi_cnt++;
                        if (first_hi < 0) first_hi = n;
                    end
                end
            end
        join
        repeat (4) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [SW-1:0] cfg_a, cfg_b, rsh, sh;
        logic [50:0]   p;
        logic [7:0]    e_ie, e_oe, e_pd, e_pu, e_sl, e_cs;
        logic [7:0]    prev_a;
        exp_t          e;
        int            r0, v0, lowc, hi, first;

        // Reset asserted mid-cycle: outputs must be safe before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst pad_OE", pad_OE, 8'h00);
        check("rst pad_PD", pad_PD, 8'hFF);
        check("rst pad_PU", pad_PU, 8'h00);
        check("rst pad_IE", pad_IE, 8'h00);
        check("rst pad_A", pad_A, 8'h00);
        check("rst core_in", core_in, 8'h00);
        check("rst cfg_busy", cfg_busy, 1'b0);
        check("rst cfg_sdo", cfg_sdo, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Pad0 output with pull-up, all others input.
        for (int i = 0; i < N; i++)
            cfg_a[6*i +: 6] = (i == 0) ? pw(2'b10, 2'b10, 1'b0, 1'b0) : pw(2'b01, 2'b00, 1'b0, 1'b0);
        shift_cfg(cfg_a);
        check("A pre-apply pad_IE", pad_IE, 8'h00);
        check("A pre-apply pad_PD", pad_PD, 8'hFF);
        r0 = busy_rises;
        v0 = oe_viol;
        pulse_apply();
        wait_idle("A idle");
        check("A busy runs", busy_rises - r0, 1);
        check("A busy length", busy_last, 5);
        check("A OE during busy", oe_viol - v0, 0);
        check("A pad_OE", pad_OE, 8'h01);
        check("A pad_PU", pad_PU, 8'h01);
        check("A pad_PD", pad_PD, 8'h00);
        check("A pad_IE", pad_IE, 8'hFE);

        // Pad0 output, pad3 bidir, pad5 output with SL/CS, others input.
        for (int i = 0; i < N; i++) begin
            case (i)
                0:       cfg_b[6*i +: 6] = pw(2'b10, 2'b00, 1'b0, 1'b0);
                3:       cfg_b[6*i +: 6] = pw(2'b11, 2'b00, 1'b0, 1'b0);
                5:       cfg_b[6*i +: 6] = pw(2'b10, 2'b00, 1'b1, 1'b1);
                default: cfg_b[6*i +: 6] = pw(2'b01, 2'b00, 1'b0, 1'b0);
            endcase
        end
        shift_cfg(cfg_b);
        pulse_apply();
        wait_idle("B idle");
        check("B pad_SL", pad_SL, 8'h20);
        check("B pad_CS", pad_CS, 8'h20);
        check("B pad_IE", pad_IE, 8'hDE);
        check("B pad_PD", pad_PD, 8'h00);

        vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h21};
        vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h21};
        vecs[2] = '{8'hA5, 8'h08, 8'hA5, 8'h29};
        vecs[3] = '{8'h5A, 8'hF7, 8'h5A, 8'h21};
        vecs[4] = '{8'h3C, 8'hFF, 8'h3C, 8'h29};
        vecs[5] = '{8'h00, 8'h08, 8'h00, 8'h29};
        prev_a = 8'h00;
        for (int i = 0; i < 6; i++) begin
            core_out = vecs[i].co;
            core_oe  = vecs[i].coe;
            sb_q.push_back('{vecs[i].ea, vecs[i].eoe});
            @(negedge clk);
            check("vec pad_A latency", pad_A, prev_a);
            tick();
            e = sb_q.pop_front();
            check("vec pad_A", pad_A, e.a);
            check("vec pad_OE", pad_OE, e.oe);
            prev_a = e.a;
        end

        // Recommit with bidir pad3 enabled: OE must drop for the whole sequence.
        pulse_apply();
        lowc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (!pad_OE[3]) lowc++;
        end
        tick();
        wait_idle("C idle");
        check("C OE3 low cycles", lowc, 5);
        check("C pad_OE after", pad_OE, 8'h29);

        // Second request in DRAIN and a third in APPLY merge into one extra commit.
        r0 = busy_rises;
        v0 = oe_viol;
        cfg_apply = 1'b1; tick();
        cfg_apply = 1'b0; tick();
        cfg_apply = 1'b1; tick();
        cfg_apply = 1'b0; tick();
        tick();
        cfg_apply = 1'b1; tick();
        cfg_apply = 1'b0;
        wait_idle("D idle");
        repeat (4) tick();
        check("D busy runs", busy_rises - r0, 1);
        check("D busy length", busy_last, 10);
        check("D OE during busy", oe_viol - v0, 0);
        check("D busy after", cfg_busy, 1'b0);

        // Deglitch on input pad1; output pad0 has IE=0 so its core_in stays low.
        repeat (4) tick();
        pulse_pad(1, 1, hi, first);
        check("E glitch1 hi", hi, 0);
        pulse_pad(1, 2, hi, first);
        check("E glitch2 hi", hi, 0);
        pulse_pad(1, 4, hi, first);
        check("E pulse4 latency", first, 5);
        check("E pulse4 width", hi, 4);
        pulse_pad(0, 8, hi, first);
        check("E IE gate", hi, 0);

        // Reset in the middle of a commit.
        pad_Y[1] = 1'b1;
        repeat (8) tick();
        check("F core_in pre", core_in, 8'h02);
        pulse_apply();
        tick();
        check("F busy pre", cfg_busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("F rst pad_OE", pad_OE, 8'h00);
        check("F rst pad_PD", pad_PD, 8'hFF);
        check("F rst core_in", core_in, 8'h00);
        check("F rst cfg_busy", cfg_busy, 1'b0);
        check("F rst pad_IE", pad_IE, 8'h00);
        pad_Y = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        pulse_apply();
        wait_idle("F idle");
        check("F lost shadow PD", pad_PD, 8'hFF);
        check("F lost shadow IE", pad_IE, 8'h00);

        // Chain pass-through: 51 bits, sdo lags sdi by 48 cycles.
        for (int i = 0; i < 51; i++) p[i] = 1'($urandom_range(0, 1));
        p[0] = 1'b1;
        p[1] = 1'b0;
        p[2] = 1'b1;
        rsh = {N{6'b000100}};
        for (int n = 0; n < 51; n++) begin
            cfg_shift = 1'b1;
            cfg_sdi   = p[n];
            if (n >= SW) check("G sdo delayed", cfg_sdo, p[n-SW]);
            else         check("G sdo reset shadow", cfg_sdo, rsh[SW-1-n]);
            tick();
        end
        cfg_shift = 1'b0;
        cfg_sdi   = 1'b0;
        check("G sdo final", cfg_sdo, p[3]);
        check("G pre-apply IE", pad_IE, 8'h00);
        check("G pre-apply OE", pad_OE, 8'h00);
        check("G pre-apply PD", pad_PD, 8'hFF);
        for (int j = 0; j < SW; j++) sh[SW-1-j] = p[3+j];
        for (int i = 0; i < N; i++) begin
            e_ie[i] = sh[6*i];
            e_oe[i] = (sh[6*i +: 2] == 2'b10) || ((sh[6*i +: 2] == 2'b11) && core_oe[i]);
            e_pd[i] = sh[6*i+2];
            e_pu[i] = sh[6*i+3];
            e_sl[i] = sh[6*i+4];
            e_cs[i] = sh[6*i+5];
        end
        pulse_apply();
        wait_idle("G idle");
        check("G pad_IE", pad_IE, e_ie);
        check("G pad_OE", pad_OE, e_oe);
        check("G pad_PD", pad_PD, e_pd);
        check("G pad_PU", pad_PU, e_pu);
        check("G pad_SL", pad_SL, e_sl);
        check("G pad_CS", pad_CS, e_cs);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
